// File: rtl/fifo36_tx_arbiter_if.sv
// One fifo36 stream link: 36-bit word plus src_rdy/dst_rdy handshake.
// The master drives the word; the slave returns dst_rdy.
interface fifo36_tx_arbiter_if;
    logic [35:0] data;
    logic        src_rdy;
    logic        dst_rdy;

    modport master (output data, output src_rdy, input dst_rdy);
    modport slave  (input data, input src_rdy, output dst_rdy);
endinterface

// File: rtl/fifo36_tx_arbiter.sv
// Frame-granular 2:1 arbiter for the GEMAC TX fifo36 path. A granted frame
// passes combinationally until EOF. Orphan words are dropped while idle.
module fifo36_tx_arbiter #(
    parameter int PRIO_MODE = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    fifo36_tx_arbiter_if.slave          in0,
    fifo36_tx_arbiter_if.slave          in1,
    fifo36_tx_arbiter_if.master         out,
    input  logic                        hold,
    output logic                        busy,
    output logic                        cur_port,
    output logic [15:0]                 frame_count,
    output logic [7:0]                  drop_count
);

    localparam int SOF_BIT = 32;
    localparam int EOF_BIT = 33;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PASS0 = 2'd1;
    localparam logic [1:0] ST_PASS1 = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        cur_port_q, cur_port_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;

    logic        req0, req1;
    logic        orph0, orph1;
    logic        grant;
    logic [35:0] out_data_c;
    logic        out_vld_c;
    logic        in0_rdy_c, in1_rdy_c;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, a} + {7'b0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    // Orphan acceptance is suppressed during reset/clear so every dst_rdy
    // reads low while the block is being initialised.
    always_comb begin
        req0  = in0.src_rdy & in0.data[SOF_BIT];
        req1  = in1.src_rdy & in1.data[SOF_BIT];
        orph0 = in0.src_rdy & ~in0.data[SOF_BIT] & ~reset & ~clear;
        orph1 = in1.src_rdy & ~in1.data[SOF_BIT] & ~reset & ~clear;
    end

    always_comb begin
        state_d     = state_q;
        cur_port_d  = cur_port_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        grant       = 1'b0;
        out_data_c  = '0;
        out_vld_c   = 1'b0;
        in0_rdy_c   = 1'b0;
        in1_rdy_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in0_rdy_c  = orph0;
                in1_rdy_c  = orph1;
                drop_cnt_d = sat_add8(drop_cnt_q, {1'b0, orph0} + {1'b0, orph1});
                if (!hold && (req0 || req1)) begin
                    if (req0 && req1)
                        grant = (PRIO_MODE != 0) ? 1'b0 : ~cur_port_q;
                    else
                        grant = req1;
                    state_d    = grant ? ST_PASS1 : ST_PASS0;
                    cur_port_d = grant;
                end
            end
            ST_PASS0: begin
                out_data_c = in0.data;
                out_vld_c  = in0.src_rdy;
                in0_rdy_c  = out.dst_rdy;
                if (in0.src_rdy && out.dst_rdy && in0.data[EOF_BIT]) begin
                    state_d     = ST_IDLE;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
            end
            ST_PASS1: begin
                out_data_c = in1.data;
                out_vld_c  = in1.src_rdy;
                in1_rdy_c  = out.dst_rdy;
                if (in1.src_rdy && out.dst_rdy && in1.data[EOF_BIT]) begin
                    state_d     = ST_IDLE;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cur_port_q  <= 1'b1;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else if (clear) begin
            state_q     <= ST_IDLE;
            cur_port_q  <= 1'b1;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cur_port_q  <= cur_port_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign out.data    = out_data_c;
    assign out.src_rdy = out_vld_c;
    assign in0.dst_rdy = in0_rdy_c;
    assign in1.dst_rdy = in1_rdy_c;

    assign busy        = (state_q == ST_PASS0) || (state_q == ST_PASS1);
    assign cur_port    = cur_port_q;
    assign frame_count = frame_cnt_q;
    assign drop_count  = drop_cnt_q;

endmodule

// File: tb/tb_fifo36_tx_arbiter.sv
// Randomized frame traffic against a frame-order reference model for both
// round-robin and fixed-priority arbiters fed from the same sources.
module tb_fifo36_tx_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, clear, hold, o_rdy, sel;
    logic [35:0] s0_data, s1_data;
    logic s0_vld, s1_vld;

    fifo36_tx_arbiter_if a_in0 ();
    fifo36_tx_arbiter_if a_in1 ();
    fifo36_tx_arbiter_if a_out ();
    fifo36_tx_arbiter_if b_in0 ();
    fifo36_tx_arbiter_if b_in1 ();
    fifo36_tx_arbiter_if b_out ();

    assign a_in0.data = s0_data;  assign a_in0.src_rdy = s0_vld;
    assign a_in1.data = s1_data;  assign a_in1.src_rdy = s1_vld;
    assign b_in0.data = s0_data;  assign b_in0.src_rdy = s0_vld;
    assign b_in1.data = s1_data;  assign b_in1.src_rdy = s1_vld;
    assign a_out.dst_rdy = o_rdy;
    assign b_out.dst_rdy = o_rdy;

    logic a_busy, a_cur, b_busy, b_cur;
    logic [15:0] a_fc, b_fc;
    logic [7:0] a_dc, b_dc;

    fifo36_tx_arbiter #(.PRIO_MODE(0)) u_rr (
        .clk(clk), .reset(reset), .clear(clear),
        .in0(a_in0), .in1(a_in1), .out(a_out), .hold(hold),
        .busy(a_busy), .cur_port(a_cur), .frame_count(a_fc), .drop_count(a_dc));

    fifo36_tx_arbiter #(.PRIO_MODE(1)) u_prio (
        .clk(clk), .reset(reset), .clear(clear),
        .in0(b_in0), .in1(b_in1), .out(b_out), .hold(hold),
        .busy(b_busy), .cur_port(b_cur), .frame_count(b_fc), .drop_count(b_dc));

    logic        ob_d0, ob_d1, ob_vld, ob_busy, ob_cur;
    logic [35:0] ob_data;
    logic [15:0] ob_fc;
    logic [7:0]  ob_dc;
    assign ob_d0   = sel ? b_in0.dst_rdy : a_in0.dst_rdy;
    assign ob_d1   = sel ? b_in1.dst_rdy : a_in1.dst_rdy;
    assign ob_vld  = sel ? b_out.src_rdy : a_out.src_rdy;
    assign ob_data = sel ? b_out.data    : a_out.data;
    assign ob_busy = sel ? b_busy : a_busy;
    assign ob_cur  = sel ? b_cur  : a_cur;
    assign ob_fc   = sel ? b_fc   : a_fc;
    assign ob_dc   = sel ? b_dc   : a_dc;

    int checks = 0;
    int failures = 0;

    logic [35:0] q0[$], q1[$], obs[$], exp_q[$];
    logic [35:0] f0_words[$], f1_words[$];
    int f0_len[$], f1_len[$];
    bit en0, en1, rand_stall;

    logic        sn_d0, sn_d1, sn_vld, sn_busy, sn_cur;
    logic [35:0] sn_data;
    logic [15:0] sn_fc;
    logic [7:0]  sn_dc;
    bit x0, x1, xo;

    int  last_xfer, d1_early;
    bit  timed_out;

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    // Present queue heads, let the combinational paths settle, snapshot, pop.
    task automatic sample_cycle();
        s0_vld  = en0 && (q0.size() > 0);
        s0_data = s0_vld ? q0[0] : 36'h0;
        s1_vld  = en1 && (q1.size() > 0);
        s1_data = s1_vld ? q1[0] : 36'h0;
        if (rand_stall) o_rdy = ($urandom_range(0, 3) != 0);
        #2;
        sn_d0 = ob_d0;  sn_d1 = ob_d1;  sn_vld = ob_vld;  sn_data = ob_data;
        sn_busy = ob_busy;  sn_cur = ob_cur;  sn_fc = ob_fc;  sn_dc = ob_dc;
        x0 = s0_vld && sn_d0;
        x1 = s1_vld && sn_d1;
        xo = sn_vld && o_rdy;
        if (x0) void'(q0.pop_front());
        if (x1) void'(q1.pop_front());
        if (xo) obs.push_back(sn_data);
    endtask

    task automatic do_reset();
        reset = 1'b1; clear = 1'b0; hold = 1'b0; o_rdy = 1'b1;
        s0_vld = 1'b0; s1_vld = 1'b0; s0_data = '0; s1_data = '0;
        en0 = 1'b1; en1 = 1'b1; rand_stall = 1'b0;
        q0.delete(); q1.delete(); obs.delete(); exp_q.delete();
        f0_words.delete(); f1_words.delete(); f0_len.delete(); f1_len.delete();
        advance();
        advance();
        reset = 1'b0;
    endtask

    task automatic make_frame(input int port, input int len);
        logic [35:0] w;
        for (int i = 0; i < len; i++) begin
            w = {2'($urandom), (i == len - 1), (i == 0), 32'($urandom)};
            if (port == 0) begin q0.push_back(w); f0_words.push_back(w); end
            else           begin q1.push_back(w); f1_words.push_back(w); end
        end
        if (port == 0) f0_len.push_back(len); else f1_len.push_back(len);
    endtask

    task automatic push_orphans(input int port, input int n);
        logic [35:0] w;
        for (int i = 0; i < n; i++) begin
            w = {2'($urandom), 1'($urandom), 1'b0, 32'($urandom)};
            if (port == 0) q0.push_back(w); else q1.push_back(w);
        end
    endtask

    // Whole-frame order: contention goes to port 0 under priority, else to
    // the port not granted last (port 0 first after reset).
    task automatic build_expected(input bit prio);
        int p0, p1, i0, i1;
        bit pick, turn;
        p0 = 0; p1 = 0; i0 = 0; i1 = 0; turn = 1'b0;
        exp_q.delete();
        while (i0 < f0_len.size() || i1 < f1_len.size()) begin
            if (i0 < f0_len.size() && i1 < f1_len.size()) pick = prio ? 1'b0 : turn;
            else pick = (i0 < f0_len.size()) ? 1'b0 : 1'b1;
            if (!pick) begin
                for (int k = 0; k < f0_len[i0]; k++) exp_q.push_back(f0_words[p0 + k]);
                p0 += f0_len[i0]; i0++;
            end else begin
                for (int k = 0; k < f1_len[i1]; k++) exp_q.push_back(f1_words[p1 + k]);
                p1 += f1_len[i1]; i1++;
            end
            turn = ~pick;
        end
    endtask

    task automatic run_traffic(input int bound);
        int cyc;
        bit pre0, done;
        cyc = 0; last_xfer = -1; d1_early = 0; timed_out = 1'b0;
        while (1) begin
            if (cyc >= bound) begin timed_out = 1'b1; break; end
            pre0 = (q0.size() > 0);
            sample_cycle();
            if (xo) last_xfer = cyc;
            if (sn_d1 && pre0) d1_early++;
            done = (q0.size() == 0) && (q1.size() == 0) && !sn_busy;
            advance();
            cyc++;
            if (done) break;
        end
    endtask

    task automatic compare_stream(input string name);
        int n;
        checks++;
        if (obs.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL %s_len: got %0d words expected %0d", name, obs.size(), exp_q.size());
        end
        n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL %s_word%0d: got %h expected %h", name, i, obs[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset();
        sel = 1'b0;
        do_reset();
        sample_cycle();
        checks++; if (sn_busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", sn_busy); end
        checks++; if (sn_cur !== 1'b1) begin failures++; $display("FAIL rst_cur_port: got %b expected 1", sn_cur); end
        checks++; if (sn_fc !== 16'd0) begin failures++; $display("FAIL rst_frame_count: got %0d expected 0", sn_fc); end
        checks++; if (sn_dc !== 8'd0) begin failures++; $display("FAIL rst_drop_count: got %0d expected 0", sn_dc); end
        checks++; if (sn_vld !== 1'b0) begin failures++; $display("FAIL rst_out_src_rdy: got %b expected 0", sn_vld); end
        checks++; if ({sn_d0, sn_d1} !== 2'b00) begin failures++; $display("FAIL rst_dst_rdy: got %b expected 00", {sn_d0, sn_d1}); end
        checks++; if (sn_data !== 36'h0) begin failures++; $display("FAIL rst_out_data: got %h expected 0", sn_data); end
        advance();
    endtask

    task automatic test_single_frame();
        logic [35:0] w[4];
        sel = 1'b0;
        do_reset();
        make_frame(0, 4);
        for (int i = 0; i < 4; i++) w[i] = q0[i];
        sample_cycle();
        checks++;
        if ({sn_busy, sn_vld, sn_d0} !== 3'b000 || sn_data !== 36'h0) begin
            failures++; $display("FAIL sf_bubble: got busy/vld/rdy %b data %h expected 000 and 0", {sn_busy, sn_vld, sn_d0}, sn_data);
        end
        advance();
        for (int k = 0; k < 4; k++) begin
            sample_cycle();
            checks++;
            if ({sn_busy, sn_vld, sn_d0, sn_d1} !== 4'b1110 || sn_data !== w[k]) begin
                failures++; $display("FAIL sf_word%0d: got flags %b data %h expected 1110 data %h", k, {sn_busy, sn_vld, sn_d0, sn_d1}, sn_data, w[k]);
            end
            advance();
        end
        sample_cycle();
        checks++; if (sn_busy !== 1'b0) begin failures++; $display("FAIL sf_busy_after: got %b expected 0", sn_busy); end
        checks++; if (sn_fc !== 16'd1) begin failures++; $display("FAIL sf_frame_count: got %0d expected 1", sn_fc); end
        checks++; if (sn_cur !== 1'b0) begin failures++; $display("FAIL sf_cur_port: got %b expected 0", sn_cur); end
        advance();
    endtask

    task automatic test_round_robin();
        sel = 1'b0;
        do_reset();
        for (int f = 0; f < 2; f++) begin make_frame(0, 3); make_frame(1, 3); end
        build_expected(1'b0);
        run_traffic(200);
        checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL rr_timeout: got %b expected 0", timed_out); end
        compare_stream("rr");
        checks++; if (a_fc !== 16'd4) begin failures++; $display("FAIL rr_frame_count: got %0d expected 4", a_fc); end
        checks++; if (last_xfer !== 15) begin failures++; $display("FAIL rr_cycles: got last transfer at %0d expected 15", last_xfer); end
        checks++; if (a_cur !== 1'b1) begin failures++; $display("FAIL rr_cur_port: got %b expected 1", a_cur); end
    endtask

    task automatic test_rr_random();
        int n0, n1;
        sel = 1'b0;
        do_reset();
        rand_stall = 1'b1;
        n0 = $urandom_range(2, 5);
        n1 = $urandom_range(2, 5);
        for (int f = 0; f < n0; f++) make_frame(0, $urandom_range(1, 6));
        for (int f = 0; f < n1; f++) make_frame(1, $urandom_range(1, 6));
        build_expected(1'b0);
        run_traffic(2000);
        rand_stall = 1'b0; o_rdy = 1'b1;
        checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL rrr_timeout: got %b expected 0", timed_out); end
        compare_stream("rrr");
        checks++; if (a_fc !== 16'(n0 + n1)) begin failures++; $display("FAIL rrr_frame_count: got %0d expected %0d", a_fc, n0 + n1); end
    endtask

    task automatic test_fixed_prio();
        sel = 1'b1;
        do_reset();
        rand_stall = 1'b1;
        for (int f = 0; f < 3; f++) begin make_frame(0, 3); make_frame(1, $urandom_range(1, 4)); end
        build_expected(1'b1);
        run_traffic(2000);
        rand_stall = 1'b0; o_rdy = 1'b1;
        checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL prio_timeout: got %b expected 0", timed_out); end
        compare_stream("prio");
        checks++; if (d1_early !== 0) begin failures++; $display("FAIL prio_in1_rdy: got %0d early cycles expected 0", d1_early); end
        checks++; if (b_fc !== 16'd6) begin failures++; $display("FAIL prio_frame_count: got %0d expected 6", b_fc); end
        sel = 1'b0;
    endtask

    task automatic test_orphan_drop();
        int bad;
        sel = 1'b0;
        do_reset();
        push_orphans(1, 3);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            sample_cycle();
            if (sn_d1 !== 1'b1 || sn_vld !== 1'b0) bad++;
            advance();
        end
        sample_cycle();
        checks++; if (bad !== 0) begin failures++; $display("FAIL orph_rdy: got %0d bad cycles expected 0", bad); end
        checks++; if (sn_dc !== 8'd3) begin failures++; $display("FAIL orph_count3: got %0d expected 3", sn_dc); end
        advance();
        push_orphans(1, 300);
        for (int i = 0; i < 300; i++) begin sample_cycle(); advance(); end
        sample_cycle();
        checks++; if (sn_dc !== 8'd255) begin failures++; $display("FAIL orph_saturate: got %0d expected 255", sn_dc); end
        advance();

        do_reset();
        push_orphans(0, 2);
        push_orphans(1, 2);
        for (int i = 0; i < 2; i++) begin sample_cycle(); advance(); end
        sample_cycle();
        checks++; if (sn_dc !== 8'd4) begin failures++; $display("FAIL orph_dual: got %0d expected 4", sn_dc); end
        advance();

        do_reset();
        hold = 1'b1;
        make_frame(0, 2);
        push_orphans(1, 1);
        sample_cycle();
        checks++; if ({sn_d0, sn_d1} !== 2'b01) begin failures++; $display("FAIL orph_hold_rdy: got %b expected 01", {sn_d0, sn_d1}); end
        advance();
        sample_cycle();
        checks++; if (sn_dc !== 8'd1) begin failures++; $display("FAIL orph_hold_count: got %0d expected 1", sn_dc); end
        advance();
        hold = 1'b0;
    endtask

    task automatic test_hold();
        int bad;
        logic [35:0] w[4];
        sel = 1'b0;
        do_reset();
        hold = 1'b1;
        make_frame(0, 4);
        for (int i = 0; i < 4; i++) w[i] = q0[i];
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            sample_cycle();
            if (sn_busy || sn_d0 || sn_vld || !s0_vld) bad++;
            advance();
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL hold_block: got %0d bad cycles expected 0", bad); end
        hold = 1'b0;
        sample_cycle();
        checks++; if (sn_busy !== 1'b0) begin failures++; $display("FAIL hold_release_idle: got %b expected 0", sn_busy); end
        advance();
        hold = 1'b1;
        sample_cycle();
        checks++;
        if (sn_busy !== 1'b1 || sn_data !== w[0]) begin
            failures++; $display("FAIL hold_grant: got busy %b data %h expected 1 data %h", sn_busy, sn_data, w[0]);
        end
        advance();
        for (int i = 0; i < 20 && q0.size() > 0; i++) begin sample_cycle(); advance(); end
        sample_cycle();
        checks++; if (sn_fc !== 16'd1 || sn_busy !== 1'b0) begin failures++; $display("FAIL hold_midframe: got count %0d busy %b expected 1 and 0", sn_fc, sn_busy); end
        advance();
        hold = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(w[i]);
        compare_stream("hold");
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        sel = 1'b0;
        do_reset();
        make_frame(0, 5);
        for (int i = 0; i < 3; i++) begin sample_cycle(); advance(); end
        reset = 1'b1;
        sample_cycle();
        checks++;
        if ({sn_busy, sn_cur, sn_vld, sn_d0, sn_d1} !== 5'b01000 || sn_fc !== 16'd0 || sn_dc !== 8'd0 || sn_data !== 36'h0) begin
            failures++; $display("FAIL rmid_reset_vals: got flags %b fc %0d dc %0d data %h expected 01000 0 0 0", {sn_busy, sn_cur, sn_vld, sn_d0, sn_d1}, sn_fc, sn_dc, sn_data);
        end
        advance();
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            sample_cycle();
            if (sn_d0 !== 1'b1 || sn_vld !== 1'b0) bad++;
            advance();
        end
        sample_cycle();
        checks++; if (bad !== 0) begin failures++; $display("FAIL rmid_orphan_rdy: got %0d bad cycles expected 0", bad); end
        checks++; if (sn_dc !== 8'd3) begin failures++; $display("FAIL rmid_drop_count: got %0d expected 3", sn_dc); end
        advance();
        obs.delete(); f0_words.delete(); f0_len.delete();
        make_frame(0, 3);
        build_expected(1'b0);
        run_traffic(50);
        checks++; if (a_fc !== 16'd1 || timed_out !== 1'b0) begin failures++; $display("FAIL rmid_next_frame: got count %0d timeout %b expected 1 and 0", a_fc, timed_out); end
        compare_stream("rmid");
    endtask

    task automatic test_clear();
        sel = 1'b0;
        do_reset();
        make_frame(1, 1);
        run_traffic(20);
        make_frame(0, 4);
        for (int i = 0; i < 2; i++) begin sample_cycle(); advance(); end
        clear = 1'b1;
        sample_cycle();
        advance();
        clear = 1'b0;
        sample_cycle();
        checks++;
        if ({sn_busy, sn_cur} !== 2'b01 || sn_fc !== 16'd0 || sn_dc !== 8'd0) begin
            failures++; $display("FAIL clr_vals: got busy/cur %b fc %0d dc %0d expected 01 0 0", {sn_busy, sn_cur}, sn_fc, sn_dc);
        end
        checks++; if (sn_d0 !== 1'b1) begin failures++; $display("FAIL clr_orphan: got %b expected 1", sn_d0); end
        advance();
    endtask

    initial begin
        sel = 1'b0;
        test_reset();
        test_single_frame();
        test_round_robin();
        test_rr_random();
        test_fixed_prio();
        test_orphan_drop();
        test_hold();
        test_reset_mid_frame();
        test_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo36_tx_arbiter.md
Name: fifo36_tx_arbiter

Overview:
- Frame-granular 2:1 arbiter that shares the GEMAC TX client fifo36 path between two frame sources, such as a CPU packet path and a DSP/streaming path.
- Sits in sys_clk domain directly ahead of the TX 2-clock FIFO's fifo36 write side.
- Once a frame is granted, it passes through uninterrupted until its EOF; frames are never interleaved.
- Also discards orphan words that lack SOF, provides a start-of-frame hold-off, and keeps frame/drop counters.

Parameters:
- PRIO_MODE, 0, 0 = round-robin between ports; 1 = fixed priority, port 0 always wins simultaneous requests.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- clear  in  1  synchronous clear; same effect as reset
- in0_data  in  36  port 0 fifo36 word ([32]=sof, [33]=eof, [35:34]=occ)
- in0_src_rdy  in  1  port 0 word valid
- in0_dst_rdy  out  1  port 0 word accepted
- in1_data  in  36  port 1 fifo36 word
- in1_src_rdy  in  1  port 1 word valid
- in1_dst_rdy  out  1  port 1 word accepted
- out_data  out  36  muxed fifo36 word
- out_src_rdy  out  1  output valid
- out_dst_rdy  in  1  downstream ready
- hold  in  1  block start of new frames; frames already in progress complete
- busy  out  1  a frame is in progress
- cur_port  out  1  port currently or last granted
- frame_count  out  16  frames completed (EOF transferred), wraps
- drop_count  out  8  orphan words discarded, saturates at 255

Behaviour:
- Transfer rule: a word moves on a port when that port's src_rdy and dst_rdy are both high in the same cycle.
- State machine has three states: IDLE, PASS0, PASS1.
- Reset/clear values: state=IDLE, cur_port=1 (so round-robin favours port 0 first), frame_count=0, drop_count=0, busy=0, out_src_rdy=0, in*_dst_rdy=0.
- In IDLE, a port "requests" when its src_rdy=1 and data[32]=1.
- In IDLE with hold=0, requests are granted as follows:
  - Only one port requests: grant that port.
  - Both ports request, PRIO_MODE=0: grant the port != cur_port.
  - Both ports request, PRIO_MODE=1: grant port 0.
  - The grant registers at the clock edge: next state becomes PASS<n>, cur_port<=n.
  - No word is transferred in the IDLE cycle; the grant costs 1 bubble cycle.
- In IDLE with hold=1, there is no grant regardless of requests.
- Orphan words in IDLE:
  - A port with src_rdy=1 and data[32]=0 has its dst_rdy driven high combinationally, so the word is discarded.
  - drop_count increments by 1 per discarded word; two ports discarding in the same cycle add 2, saturating at 255.
  - Orphans are discarded even when hold=1.
  - A port that is requesting (SOF present) is never discarded.
- In PASS<n>:
  - out_data = in<n>_data.
  - out_src_rdy = in<n>_src_rdy.
  - in<n>_dst_rdy = out_dst_rdy.
  - The other port's dst_rdy is held 0.
  - The path is purely combinational: 0-cycle latency, no added storage.
- Leaving PASS<n>: on transfer of a word with data[33]=1, the next state is IDLE and frame_count increments (mod 2^16).
- A single-word frame (sof=1 and eof=1) is legal: PASS for 1 transfer, then IDLE.
- A SOF arriving mid-frame in PASS is passed through unchanged; there is no frame repair.
- hold has no effect in the PASS states.
- In IDLE: out_src_rdy=0 and out_data=0.
- busy=1 exactly when state is PASS0 or PASS1.
- Sustained contention, PRIO_MODE=0: grants strictly alternate 0,1,0,1.
- Sustained contention, PRIO_MODE=1: port 1 can starve; this is acceptable and documented.
- Reset or clear during a frame: the machine returns to IDLE immediately and the remainder of that frame's words become orphans and are dropped. This is required behaviour.
- out_dst_rdy low during PASS stalls the granted source; the state is held, with no timeout.

Test Plan:
- Port 0 sends a 4-word frame (sof on w0, eof on w3), port 1 idle, out_dst_rdy=1 -> grant after 1 bubble, 4 consecutive output words identical to input, busy high for 4 cycles, frame_count=1, cur_port=0.
- PRIO_MODE=0, both ports continuously offer 3-word frames -> output frame order is 0,1,0,1, never interleaved, frame_count=4 after 4 frames plus 4 bubble cycles.
- PRIO_MODE=1, same stimulus as the previous scenario -> only port 0 frames appear, in1_dst_rdy is never asserted.
- Port 1 presents 3 words with sof=0 while in IDLE -> in1_dst_rdy high on each, drop_count=3, out_src_rdy stays 0. Then present 300 such words -> drop_count saturates at 255.
- hold=1 with port 0 requesting -> no grant for 10 cycles. Deassert hold -> grant on the next edge. Assert hold mid-frame -> frame still completes to eof.
- Assert reset for 1 cycle after word 2 of a 5-word frame -> all outputs at reset values. Words 3–5 (sof=0) are dropped, drop_count=3. The next sof frame is granted normally.
